// File: rtl/matrix_axi_bridge.sv
// AXI4-Lite target issuing single-cell weight writes/reads on the coupling matrix config port.
// Latency: write strobe 1 cycle after AW/W handshake, B the cycle after; R READ_WAIT+1 cycles after AR.
// Backpressure: one transaction outstanding; no channel re-accepted until B or R handshake completes.
module matrix_axi_bridge #(
    parameter int N         = 8,
    parameter int READ_WAIT = 4,
    localparam int L        = $clog2(N)
) (
    input  logic          clk,
    input  logic          axi_rstn,
    input  logic [31:0]   s_axi_awaddr,
    input  logic          s_axi_awvalid,
    output logic          s_axi_awready,
    input  logic [31:0]   s_axi_wdata,
    input  logic          s_axi_wvalid,
    output logic          s_axi_wready,
    output logic [1:0]    s_axi_bresp,
    output logic          s_axi_bvalid,
    input  logic          s_axi_bready,
    input  logic [31:0]   s_axi_araddr,
    input  logic          s_axi_arvalid,
    output logic          s_axi_arready,
    output logic [31:0]   s_axi_rdata,
    output logic [1:0]    s_axi_rresp,
    output logic          s_axi_rvalid,
    input  logic          s_axi_rready,
    output logic          m_wr_match,
    output logic          m_wready,
    output logic [L:0]    m_s_addr,
    output logic [L:0]    m_d_addr,
    output logic          m_vh,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR    = 3'd1;
    localparam logic [2:0] BRESP = 3'd2;
    localparam logic [2:0] RD    = 3'd3;
    localparam logic [2:0] RRESP = 3'd4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [2:0] state;
    logic [3:0] cnt;

    logic aw_legal, ar_legal, w_hs, r_hs;
    logic unused_addr_bits;

    // Anything above the vh bit is outside the matrix window.
    assign aw_legal = (s_axi_awaddr >> (3 + 2 * L)) == 32'd0;
    assign ar_legal = (s_axi_araddr >> (3 + 2 * L)) == 32'd0;
    assign w_hs     = s_axi_awready & s_axi_wready & s_axi_awvalid & s_axi_wvalid;
    assign r_hs     = s_axi_arready & s_axi_arvalid;
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bresp   <= OKAY;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rdata   <= 32'd0;
            s_axi_rresp   <= OKAY;
            s_axi_rvalid  <= 1'b0;
            m_wr_match    <= 1'b0;
            m_wready      <= 1'b0;
            m_s_addr      <= '0;
            m_d_addr      <= '0;
            m_vh          <= 1'b0;
            m_wdata       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (w_hs) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        // The matrix root splits on bit L, so indices sit one bit up.
                        m_d_addr      <= {s_axi_awaddr[2 +: L], 1'b0};
                        m_s_addr      <= {s_axi_awaddr[2 + L +: L], 1'b0};
                        m_vh          <= s_axi_awaddr[2 + 2 * L];
                        m_wdata       <= s_axi_wdata;
                        if (aw_legal) begin
                            state      <= WR;
                            m_wr_match <= 1'b1;
                            m_wready   <= 1'b1;
                        end else begin
                            state        <= BRESP;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= SLVERR;
                        end
                    end else if (r_hs) begin
                        s_axi_arready <= 1'b0;
                        m_d_addr      <= {s_axi_araddr[2 +: L], 1'b0};
                        m_s_addr      <= {s_axi_araddr[2 + L +: L], 1'b0};
                        m_vh          <= s_axi_araddr[2 + 2 * L];
                        if (ar_legal) begin
                            state      <= RD;
                            m_wr_match <= 1'b1;
                            cnt        <= 4'(READ_WAIT - 1);
                        end else begin
                            state        <= RRESP;
                            s_axi_rvalid <= 1'b1;
                            s_axi_rresp  <= SLVERR;
                            s_axi_rdata  <= 32'hAAAA_AAAA;
                        end
                    end else if (!s_axi_awready && !s_axi_arready) begin
                        // A complete write pair outranks a pending read.
                        if (s_axi_awvalid && s_axi_wvalid) begin
                            s_axi_awready <= 1'b1;
                            s_axi_wready  <= 1'b1;
                        end else if (s_axi_arvalid) begin
                            s_axi_arready <= 1'b1;
                        end
                    end
                end
                WR: begin
                    m_wr_match   <= 1'b0;
                    m_wready     <= 1'b0;
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= OKAY;
                    state        <= BRESP;
                end
                BRESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                RD: begin
                    // m_rdata is combinational through the tree; sample only after it settles.
                    if (cnt == 4'd0) begin
                        s_axi_rdata  <= m_rdata;
                        s_axi_rresp  <= OKAY;
                        s_axi_rvalid <= 1'b1;
                        m_wr_match   <= 1'b0;
                        state        <= RRESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RRESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
